// File: rtl/randomizer_pkg.sv
// Shared definitions for the multi-channel LFSR randomizer: sizing helper,
// maximal-length XNOR tap table and FSM states.
package randomizer_pkg;

    typedef enum logic {INIT, RUN} rnd_state_e;

    function automatic int clog2(input int n);
        int r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    function automatic logic [63:0] tap_set(input int a, input int b, input int c,
                                            input int d, input int e);
        logic [63:0] t;
        t    = '0;
        t[a] = 1'b1;
        t[b] = 1'b1;
        t[c] = 1'b1;
        t[d] = 1'b1;
        t[e] = 1'b1;
        t[0] = 1'b0;
        return t;
    endfunction

    // Bit i set means shifted bit i is XNORed with the feedback bit; the top tap is implicit.
    function automatic logic [63:0] lfsr_tap(input int width);
        case (width)
            3:  return tap_set(2, 0, 0, 0, 0);      4:  return tap_set(3, 0, 0, 0, 0);
            5:  return tap_set(3, 0, 0, 0, 0);      6:  return tap_set(5, 0, 0, 0, 0);
            7:  return tap_set(6, 0, 0, 0, 0);      8:  return tap_set(6, 5, 4, 0, 0);
            9:  return tap_set(5, 0, 0, 0, 0);      10: return tap_set(7, 0, 0, 0, 0);
            11: return tap_set(9, 0, 0, 0, 0);      12: return tap_set(6, 4, 1, 0, 0);
            13: return tap_set(4, 3, 1, 0, 0);      14: return tap_set(5, 3, 1, 0, 0);
            15: return tap_set(14, 0, 0, 0, 0);     16: return tap_set(15, 13, 4, 0, 0);
            17: return tap_set(14, 0, 0, 0, 0);     18: return tap_set(11, 0, 0, 0, 0);
            19: return tap_set(6, 2, 1, 0, 0);      20: return tap_set(17, 0, 0, 0, 0);
            21: return tap_set(19, 0, 0, 0, 0);     22: return tap_set(21, 0, 0, 0, 0);
            23: return tap_set(18, 0, 0, 0, 0);     24: return tap_set(23, 22, 17, 0, 0);
            25: return tap_set(22, 0, 0, 0, 0);     26: return tap_set(6, 2, 1, 0, 0);
            27: return tap_set(5, 2, 1, 0, 0);      28: return tap_set(25, 0, 0, 0, 0);
            29: return tap_set(27, 0, 0, 0, 0);     30: return tap_set(6, 4, 1, 0, 0);
            31: return tap_set(28, 0, 0, 0, 0);     32: return tap_set(22, 2, 1, 0, 0);
            33: return tap_set(20, 0, 0, 0, 0);     34: return tap_set(27, 2, 1, 0, 0);
            35: return tap_set(33, 0, 0, 0, 0);     36: return tap_set(25, 0, 0, 0, 0);
            37: return tap_set(5, 4, 3, 2, 1);      38: return tap_set(6, 5, 1, 0, 0);
            39: return tap_set(35, 0, 0, 0, 0);     40: return tap_set(38, 21, 19, 0, 0);
            41: return tap_set(38, 0, 0, 0, 0);     42: return tap_set(41, 20, 19, 0, 0);
            43: return tap_set(42, 38, 37, 0, 0);   44: return tap_set(43, 18, 17, 0, 0);
            45: return tap_set(44, 42, 41, 0, 0);   46: return tap_set(45, 26, 25, 0, 0);
            47: return tap_set(42, 0, 0, 0, 0);     48: return tap_set(47, 21, 20, 0, 0);
            49: return tap_set(40, 0, 0, 0, 0);     50: return tap_set(49, 24, 23, 0, 0);
            51: return tap_set(50, 36, 35, 0, 0);   52: return tap_set(49, 0, 0, 0, 0);
            53: return tap_set(52, 38, 37, 0, 0);   54: return tap_set(53, 18, 17, 0, 0);
            55: return tap_set(31, 0, 0, 0, 0);     56: return tap_set(55, 35, 34, 0, 0);
            57: return tap_set(50, 0, 0, 0, 0);     58: return tap_set(39, 0, 0, 0, 0);
            59: return tap_set(58, 38, 37, 0, 0);   60: return tap_set(59, 0, 0, 0, 0);
            61: return tap_set(60, 46, 45, 0, 0);   62: return tap_set(61, 6, 5, 0, 0);
            63: return tap_set(62, 0, 0, 0, 0);     64: return tap_set(63, 61, 60, 0, 0);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/randomizer_mc_lfsr_step.sv
// One combinational Galois XNOR LFSR shift; chained by the top for multi-step advance.
module lfsr_step
    import randomizer_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 32
) (
    input  logic [OUTPUT_WIDTH-1:0] din,
    output logic [OUTPUT_WIDTH-1:0] dout
);

    localparam logic [63:0] TAP = lfsr_tap(OUTPUT_WIDTH);

    assign dout[OUTPUT_WIDTH-1] = din[0];

    for (genvar i = 1; i < OUTPUT_WIDTH; i++) begin : g_bit
        if (TAP[i]) begin : g_tap
            assign dout[i-1] = ~(din[i] ^ din[0]);
        end else begin : g_pass
            assign dout[i-1] = din[i];
        end
    end

endmodule

// File: rtl/randomizer_mc.sv
// Multi-channel handshaked LFSR randomizer with a one-entry output register.
// Define RANDOMIZER_TPDF_EN for triangular-PDF output (two chained draws averaged).
module randomizer_mc
    import randomizer_pkg::*;
#(
    parameter int                      NR_CHANNELS   = 8,
    parameter int                      OUTPUT_WIDTH  = 32,
    parameter int                      STEPS         = 1,
    parameter logic [OUTPUT_WIDTH-1:0] DEFAULT_SEED  = '0,
    localparam int                     CHANNEL_WIDTH = (clog2(NR_CHANNELS) < 1) ? 1 : clog2(NR_CHANNELS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CHANNEL_WIDTH-1:0] rndm_ch,
    input  logic                     rndm_req,
    output logic                     rndm_ready,
    input  logic [OUTPUT_WIDTH-1:0]  rndm_seed,
    input  logic                     rndm_init,
    output logic [OUTPUT_WIDTH-1:0]  rndm_out,
    output logic [CHANNEL_WIDTH-1:0] rndm_out_ch,
    output logic                     rndm_out_valid,
    input  logic                     rndm_out_ready
);

`ifdef RANDOMIZER_TPDF_EN
    localparam int NR_SHIFTS = 2 * STEPS;
`else
    localparam int NR_SHIFTS = STEPS;
`endif
    localparam logic [OUTPUT_WIDTH-1:0] ALL_ONES = '1;

    rnd_state_e               state;
    logic [CHANNEL_WIDTH-1:0] sweep_cnt;
    logic [OUTPUT_WIDTH-1:0]  lfsr_ch [NR_CHANNELS];
    logic [OUTPUT_WIDTH-1:0]  chain [NR_SHIFTS+1];
    logic [OUTPUT_WIDTH-1:0]  next_state;
    logic [OUTPUT_WIDTH-1:0]  result;
    logic [OUTPUT_WIDTH-1:0]  seed_fixed;
    logic [OUTPUT_WIDTH-1:0]  sweep_seed;
    logic                     ch_valid;
    logic                     req_fire;

    // All-ones is the XNOR lock-up state, so it is never stored or emitted.
    function automatic logic [OUTPUT_WIDTH-1:0] no_lockup(input logic [OUTPUT_WIDTH-1:0] v);
        return (v == ALL_ONES) ? '0 : v;
    endfunction

    assign ch_valid   = int'(rndm_ch) < NR_CHANNELS;
    assign rndm_ready = (state == RUN) && (!rndm_out_valid || rndm_out_ready);
    assign req_fire   = rndm_req && rndm_ready;
    assign seed_fixed = no_lockup(rndm_seed);
    assign sweep_seed = no_lockup(DEFAULT_SEED ^ OUTPUT_WIDTH'(sweep_cnt));
    assign chain[0]   = ch_valid ? lfsr_ch[rndm_ch] : '0;

    for (genvar s = 0; s < NR_SHIFTS; s++) begin : g_step
        lfsr_step #(.OUTPUT_WIDTH(OUTPUT_WIDTH)) u_step (
            .din  (chain[s]),
            .dout (chain[s+1])
        );
    end

`ifdef RANDOMIZER_TPDF_EN
    logic [OUTPUT_WIDTH-1:0] tpdf_a;
    assign tpdf_a     = no_lockup(chain[STEPS]);
    assign next_state = no_lockup(chain[NR_SHIFTS]);
    assign result     = $unsigned(($signed(tpdf_a) >>> 1) + ($signed(next_state) >>> 1));
`else
    assign next_state = no_lockup(chain[NR_SHIFTS]);
    assign result     = next_state;
`endif

    // Seed load is written after the step result so it wins on a shared channel.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            lfsr_ch[sweep_cnt] <= sweep_seed;
        end else if (ch_valid) begin
            if (req_fire)  lfsr_ch[rndm_ch] <= next_state;
            if (rndm_init) lfsr_ch[rndm_ch] <= seed_fixed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT;
            sweep_cnt      <= '0;
            rndm_out       <= '0;
            rndm_out_ch    <= '0;
            rndm_out_valid <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == CHANNEL_WIDTH'(NR_CHANNELS - 1)) state <= RUN;
                end
                RUN: begin
                    if (req_fire && ch_valid) begin
                        rndm_out       <= result;
                        rndm_out_ch    <= rndm_ch;
                        rndm_out_valid <= 1'b1;
                    end else if (rndm_out_ready) begin
                        rndm_out_valid <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_randomizer_mc.sv
// Directed self-checking bench for randomizer_mc (4-bit LFSR, 8 channels plus a 9-channel copy).
module tb_randomizer_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rndm_ch;
    logic       rndm_req;
    logic       rndm_ready;
    logic [3:0] rndm_seed;
    logic       rndm_init;
    logic [3:0] rndm_out;
    logic [2:0] rndm_out_ch;
    logic       rndm_out_valid;
    logic       rndm_out_ready;

    logic [3:0] oor_ch;
    logic       oor_req;
    logic       oor_ready;
    logic [3:0] oor_seed;
    logic       oor_init;
    logic [3:0] oor_out;
    logic [3:0] oor_out_ch;
    logic       oor_valid;

    int checks   = 0;
    int failures = 0;

    // Hand-derived 4-bit sequence from state 0 (taps 4,3): full 15-state cycle back to 0.
    logic [3:0] exp_seq [15] = '{4'd4, 4'd6, 4'd7, 4'd11, 4'd13, 4'd14, 4'd3, 4'd9,
                                 4'd12, 4'd2, 4'd5, 4'd10, 4'd1, 4'd8, 4'd0};

    always #5 clk = ~clk;

    randomizer_mc #(.NR_CHANNELS(8), .OUTPUT_WIDTH(4), .STEPS(1), .DEFAULT_SEED(4'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rndm_ch        (rndm_ch),
        .rndm_req       (rndm_req),
        .rndm_ready     (rndm_ready),
        .rndm_seed      (rndm_seed),
        .rndm_init      (rndm_init),
        .rndm_out       (rndm_out),
        .rndm_out_ch    (rndm_out_ch),
        .rndm_out_valid (rndm_out_valid),
        .rndm_out_ready (rndm_out_ready)
    );

    randomizer_mc #(.NR_CHANNELS(9), .OUTPUT_WIDTH(4), .STEPS(1), .DEFAULT_SEED(4'h0)) u_oor (
        .clk            (clk),
        .rst_n          (rst_n),
        .rndm_ch        (oor_ch),
        .rndm_req       (oor_req),
        .rndm_ready     (oor_ready),
        .rndm_seed      (oor_seed),
        .rndm_init      (oor_init),
        .rndm_out       (oor_out),
        .rndm_out_ch    (oor_out_ch),
        .rndm_out_valid (oor_valid),
        .rndm_out_ready (1'b1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] ch, input logic req, input logic init,
                                 input logic [3:0] seed);
        rndm_ch   = ch;
        rndm_req  = req;
        rndm_init = init;
        rndm_seed = seed;
        tick();
        rndm_req  = 1'b0;
        rndm_init = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        rndm_ch        = '0;
        rndm_req       = 1'b0;
        rndm_seed      = '0;
        rndm_init      = 1'b0;
        rndm_out_ready = 1'b1;
        oor_ch         = '0;
        oor_req        = 1'b0;
        oor_seed       = '0;
        oor_init       = 1'b0;
        tick();
        tick();

        checkOutput("reset_out", rndm_out, 0);
        checkOutput("reset_out_ch", rndm_out_ch, 0);
        checkOutput("reset_valid", rndm_out_valid, 0);
        checkOutput("reset_ready", rndm_ready, 0);
        checkOutput("oor_reset_valid", oor_valid, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("init_ready_low_%0d", i), rndm_ready, 0);
            checkOutput($sformatf("init_valid_low_%0d", i), rndm_out_valid, 0);
            tick();
        end
        checkOutput("init_ready_high", rndm_ready, 1);

        $display("[TB] back-to-back requests on channel 0");
        rndm_ch  = 3'd0;
        rndm_req = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checkOutput($sformatf("seq_out_%0d", i), rndm_out, exp_seq[i]);
            checkOutput($sformatf("seq_valid_%0d", i), rndm_out_valid, 1);
            checkOutput($sformatf("seq_ready_%0d", i), rndm_ready, 1);
        end
        rndm_req = 1'b0;
        tick();
        checkOutput("consume_valid_low", rndm_out_valid, 0);

        $display("[TB] seed loads with lock-up replacement");
        applyStimulus(3'd2, 1'b0, 1'b1, 4'hF);
        applyStimulus(3'd2, 1'b1, 1'b0, 4'h0);
        checkOutput("seedF_out", rndm_out, 4);
        checkOutput("seedF_out_ch", rndm_out_ch, 2);
        applyStimulus(3'd2, 1'b0, 1'b1, 4'h4);
        applyStimulus(3'd2, 1'b1, 1'b0, 4'h0);
        checkOutput("seed4_out", rndm_out, 6);
        tick();

        $display("[TB] backpressure on channel 3");
        rndm_out_ready = 1'b0;
        applyStimulus(3'd3, 1'b1, 1'b0, 4'h0);
        checkOutput("bp_first_out", rndm_out, 9);
        rndm_ch  = 3'd3;
        rndm_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("bp_ready_low_%0d", i), rndm_ready, 0);
            checkOutput($sformatf("bp_out_hold_%0d", i), rndm_out, 9);
            checkOutput($sformatf("bp_ch_hold_%0d", i), rndm_out_ch, 3);
            checkOutput($sformatf("bp_valid_hold_%0d", i), rndm_out_valid, 1);
        end
        rndm_out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", rndm_ready, 1);
        tick();
        rndm_req = 1'b0;
        checkOutput("bp_no_advance_out", rndm_out, 12);
        tick();

        $display("[TB] simultaneous seed and request on channel 1");
        applyStimulus(3'd1, 1'b0, 1'b1, 4'h0);
        applyStimulus(3'd1, 1'b1, 1'b0, 4'h0);
        checkOutput("ch1_prep_out", rndm_out, 4);
        applyStimulus(3'd1, 1'b1, 1'b1, 4'h0);
        checkOutput("ch1_both_out", rndm_out, 6);
        checkOutput("ch1_both_out_ch", rndm_out_ch, 1);
        applyStimulus(3'd1, 1'b1, 1'b0, 4'h0);
        checkOutput("ch1_seed_wins_out", rndm_out, 4);

        $display("[TB] reset mid-stream");
        rndm_out_ready = 1'b0;
        applyStimulus(3'd0, 1'b1, 1'b0, 4'h0);
        checkOutput("pre_reset_valid", rndm_out_valid, 1);
        checkOutput("pre_reset_out", rndm_out, 4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", rndm_out_valid, 0);
        checkOutput("midreset_out", rndm_out, 0);
        checkOutput("midreset_ready", rndm_ready, 0);
        tick();
        rst_n          = 1'b1;
        rndm_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("reinit_ready_low_%0d", i), rndm_ready, 0);
            tick();
        end
        checkOutput("reinit_ready_high", rndm_ready, 1);
        applyStimulus(3'd0, 1'b1, 1'b0, 4'h0);
        checkOutput("reinit_ch0_out", rndm_out, 4);

        $display("[TB] out-of-range channel on 9-channel instance");
        checkOutput("oor_ready_high", oor_ready, 1);
        oor_ch   = 4'd9;
        oor_req  = 1'b1;
        oor_init = 1'b1;
        oor_seed = 4'h4;
        tick();
        oor_req  = 1'b0;
        oor_init = 1'b0;
        checkOutput("oor_no_valid", oor_valid, 0);
        oor_ch  = 4'd0;
        oor_req = 1'b1;
        tick();
        oor_req = 1'b0;
        checkOutput("oor_ch0_out", oor_out, 4);
        checkOutput("oor_ch0_valid", oor_valid, 1);
        oor_ch  = 4'd8;
        oor_req = 1'b1;
        tick();
        oor_req = 1'b0;
        checkOutput("oor_ch8_out", oor_out, 0);
        checkOutput("oor_ch8_out_ch", oor_out_ch, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
